exibe_sequencia: RTL
====================

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 SHALL have parameter T_LIGADO, default 1000, number of clock cycles each jogada is lit on leds.
REQ-002 SHALL have parameter T_APAGADO, default 500, number of blank cycles between consecutive jogadas.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iniciar  input  1  start request; level sampled on the rising edge of clock.
REQ-006 SHALL have port limite  input  4  index of the last jogada to display (0..15).
REQ-007 SHALL have port dado  input  4  one-hot jogada read from the sequence memory at address endereco; valid one cycle after endereco changes.
REQ-008 SHALL have port endereco  output  4  registered address into the sequence memory.
REQ-009 SHALL have port leds  output  4  jogada currently shown to the player.
REQ-010 SHALL have port exibindo  output  1  high from leaving inicial until entering final.
REQ-011 SHALL have port pronto  output  1  one-cycle pulse at the end of the display.
REQ-012 SHALL have port db_estado  output  4  current state code, for hexa7seg display.

Function
REQ-013 SHALL implement states and codes: inicial=0, preparacao=1, mostra=2, apaga=3, proximo=4, final=F.
REQ-014 SHALL move inicial->preparacao when iniciar=1; otherwise stay in inicial.
REQ-015 SHALL in preparacao clear endereco to 0, register limite into an internal limite_r, clear the timer, and move to mostra next cycle.
REQ-016 SHALL in mostra drive leds=dado, hold endereco, and count; after T_LIGADO cycles in mostra move to apaga.
REQ-017 SHALL in apaga drive leds=0000 and count; after T_APAGADO cycles move to final if endereco==limite_r, else to proximo.
REQ-018 SHALL in proximo increment endereco by 1, clear the timer, drive leds=0000, and move to mostra next cycle.
REQ-019 SHALL in final assert pronto for exactly that one cycle and move to inicial.
REQ-020 SHALL drive leds=0000 in every state except mostra.
REQ-021 SHALL ignore iniciar in every state other than inicial.
REQ-022 SHALL ignore changes on limite after preparacao.
REQ-023 SHALL, for N=limite_r+1 jogadas, make the cycle from iniciar sampled to pronto high equal to 1+N*(T_LIGADO+T_APAGADO)+(N-1)+1.
REQ-024 SHALL never let endereco wrap; limite=15 shows 16 jogadas and ends with endereco=15.
REQ-025 SHALL accept iniciar=1 held continuously, restarting from inicial immediately after final with no lost cycle beyond the inicial cycle.

Reset
REQ-026 SHALL on reset=1, asynchronously and regardless of state, force state=inicial, endereco=0, limite_r=0, timer=0.
REQ-027 SHALL hold leds=0000, exibindo=0, pronto=0, db_estado=0 while reset is high and after release until iniciar.
REQ-028 SHALL on reset mid-display abandon the sequence with no pronto pulse.

Structure
REQ-029 SHALL place state codes in a shared package with the game's other state constants.
REQ-030 SHALL use one timer sub-module contador_m (parameter M; ports clock, zera_as, zera_s, conta, Q, fim), reused for both intervals with M=max(T_LIGADO,T_APAGADO).
REQ-031 SHALL keep the memory outside the block, read through endereco/dado.

Verification (T_LIGADO=4, T_APAGADO=2)
REQ-032 SHALL check: reset, iniciar pulse, limite=0, memory[0]=0001 -> leds=0001 for 4 cycles, 0000 for 2, pronto one pulse at cycle 8 after iniciar.
REQ-033 SHALL check: limite=2, memory={0001,0100,1000} -> leds show 0001,0100,1000 in order, endereco 0->1->2, pronto at cycle 1+3*6+2+1=22.
REQ-034 SHALL check: iniciar pulsed again and limite changed to 5 during mostra -> no effect, same sequence and timing as previous case.
REQ-035 SHALL check: reset asserted in apaga of jogada 1 -> state 0, leds 0000, endereco 0 immediately, pronto never pulses.
REQ-036 SHALL check: limite=15 -> 16 jogadas shown, endereco stops at 15, no wrap to 0 before pronto.
REQ-037 SHALL check: iniciar held high -> second display starts one cycle after pronto, db_estado sequence 0,1,2,3,...,F,0,1.

Source files
------------

// File: rtl/exibe_sequencia_pkg.sv
// Shared constants for the memory game: bus widths, state codes shown on the
// hexa7seg debug display, and small elaboration helpers.
package exibe_sequencia_pkg;

    localparam int unsigned JOGADA_W = 4;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned ESTADO_W = 4;

    // Codes of the sequence-display block; they appear verbatim on db_estado.
    typedef enum logic [ESTADO_W-1:0] {
        st_inicial    = 4'h0,
        st_preparacao = 4'h1,
        st_mostra     = 4'h2,
        st_apaga      = 4'h3,
        st_proximo    = 4'h4,
        st_final      = 4'hF
    } exibe_estado_t;

    // Codes of the game-level controller, kept apart from the display codes.
    typedef enum logic [ESTADO_W-1:0] {
        jogo_inicial  = 4'h0,
        jogo_exibe    = 4'h5,
        jogo_espera   = 4'h6,
        jogo_compara  = 4'h7,
        jogo_acertou  = 4'hA,
        jogo_errou    = 4'hE
    } jogo_estado_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exibe_sequencia_contador.sv
// Modulo-M up counter used as the display interval timer.
module contador_m #(
    parameter  int unsigned M = 16,
    localparam int unsigned W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    // Synchronous clear wins over counting.
    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            Q <= '0;
        end else if (zera_s) begin
            Q <= '0;
        end else if (conta) begin
            if (Q == W'(M - 1)) begin
                Q <= '0;
            end else begin
                Q <= Q + W'(1);
            end
        end
    end

    assign fim = (Q == W'(M - 1));

endmodule

// File: rtl/exibe_sequencia.sv
// Plays back the stored jogadas 0..limite on the leds, each lit for T_LIGADO
// cycles followed by T_APAGADO blank cycles, then pulses pronto.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int unsigned T_LIGADO  = 1000,
    parameter int unsigned T_APAGADO = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [ADDR_W-1:0]   limite,
    input  logic [JOGADA_W-1:0] dado,
    output logic [ADDR_W-1:0]   endereco,
    output logic [JOGADA_W-1:0] leds,
    output logic                exibindo,
    output logic                pronto,
    output logic [ESTADO_W-1:0] db_estado
);

    localparam int unsigned M  = max_u(T_LIGADO, T_APAGADO);
    localparam int unsigned TW = (M > 1) ? $clog2(M) : 1;

    exibe_estado_t   estado, estado_prox;
    logic [ADDR_W-1:0] limite_r;
    logic [TW-1:0]   q;
    logic            fim;
    logic            fim_ligado_c, fim_apagado_c;
    logic            zera_s_c, conta_c, clr_end_c, inc_end_c, load_lim_c;

    contador_m #(.M(M)) u_timer (
        .clock  (clock),
        .zera_as(reset),
        .zera_s (zera_s_c),
        .conta  (conta_c),
        .Q      (q),
        .fim    (fim)
    );

    // The longer interval ends on the timer wrap; the shorter one on a compare.
    assign fim_ligado_c  = (T_LIGADO >= T_APAGADO) ? fim : (q == TW'(T_LIGADO - 1));
    assign fim_apagado_c = (T_APAGADO > T_LIGADO) ? fim : (q == TW'(T_APAGADO - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= st_inicial;
        end else begin
            estado <= estado_prox;
        end
    end

    // Address moves on entry to preparacao/proximo so dado is ready in mostra.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco <= '0;
            limite_r <= '0;
        end else begin
            if (clr_end_c) begin
                endereco <= '0;
            end else if (inc_end_c) begin
                endereco <= endereco + ADDR_W'(1);
            end
            if (load_lim_c) begin
                limite_r <= limite;
            end
        end
    end

    always_comb begin
        estado_prox = estado;
        zera_s_c    = 1'b0;
        conta_c     = 1'b0;
        clr_end_c   = 1'b0;
        inc_end_c   = 1'b0;
        load_lim_c  = 1'b0;
        leds        = '0;
        exibindo    = 1'b0;
        pronto      = 1'b0;
        case (estado)
            st_inicial: begin
                if (iniciar) begin
                    clr_end_c   = 1'b1;
                    estado_prox = st_preparacao;
                end
            end
            st_preparacao: begin
                exibindo    = 1'b1;
                clr_end_c   = 1'b1;
                load_lim_c  = 1'b1;
                zera_s_c    = 1'b1;
                estado_prox = st_mostra;
            end
            st_mostra: begin
                exibindo = 1'b1;
                leds     = dado;
                conta_c  = 1'b1;
                if (fim_ligado_c) begin
                    zera_s_c    = 1'b1;
                    estado_prox = st_apaga;
                end
            end
            st_apaga: begin
                exibindo = 1'b1;
                conta_c  = 1'b1;
                if (fim_apagado_c) begin
                    zera_s_c = 1'b1;
                    if (endereco == limite_r) begin
                        estado_prox = st_final;
                    end else begin
                        inc_end_c   = 1'b1;
                        estado_prox = st_proximo;
                    end
                end
            end
            st_proximo: begin
                exibindo    = 1'b1;
                zera_s_c    = 1'b1;
                estado_prox = st_mostra;
            end
            st_final: begin
                pronto      = 1'b1;
                estado_prox = st_inicial;
            end
            default: begin
                estado_prox = st_inicial;
            end
        endcase
    end

    assign db_estado = estado;

endmodule
